// File: rtl/fir_ctrl.sv
// ---------------------------------------------------------------------------
// fir_ctrl
//
// Sequencer between a streaming sample source/sink and an N-tap fir datapath.
//  - Keeps a shadow coefficient bank (written any time) and an active bank
//    (driven to the fir). A commit copies shadow->active and pulses fir_load.
//  - Sends samples to the fir one at a time as isolated fir_valid_in pulses.
//    A fixed idle gap follows every result.
//  - Stores each fir result in a 2-entry output FIFO.
//  - Handles a fir that never answers: times out, holds fir_rst for two
//    cycles, then forces a reload of the active bank.
//
// Ports
//  clk, rst            clock (rising edge) / asynchronous active-low reset
//  cfg_we/addr/wdata   shadow coefficient write; addr >= N_TAPS is ignored
//  cfg_commit          request shadow->active copy and fir reload
//  busy                FSM not idle, or a commit is pending
//  s_valid/s_ready     input sample handshake, s_data = sample
//  m_valid/m_ready     output handshake, m_data = FIFO head
//  fir_rst             active-high reset to the fir
//  fir_load            one-cycle coefficient load strobe
//  fir_coeff           active bank, tap i at [DW*i +: DW]
//  fir_valid_in        one-cycle sample strobe, fir_signal_in = sample
//  fir_valid_out       fir result strobe, fir_signal_out = result
//  err_timeout         sticky timeout flag, cleared only by reset
//  sample_cnt          number of results pushed to the FIFO (wraps)
// ---------------------------------------------------------------------------
module fir_ctrl #(
    parameter int N_TAPS  = 6,
    parameter int DW      = 16,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 32,
    localparam int AW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [DW-1:0]        cfg_wdata,
    input  logic                 cfg_commit,
    output logic                 busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_data,
    output logic                 fir_rst,
    output logic                 fir_load,
    output logic [N_TAPS*DW-1:0] fir_coeff,
    output logic                 fir_valid_in,
    output logic [DW-1:0]        fir_signal_in,
    input  logic                 fir_valid_out,
    input  logic [DW-1:0]        fir_signal_out,
    output logic                 err_timeout,
    output logic [15:0]          sample_cnt
);

    // One shared cycle counter serves WAIT, GAP and RECOVER; it restarts
    // from zero on every state change.
    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_COPY,
        S_LOAD_PULSE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_RECOVER
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic                  rst_hold_q;
    logic                  pending_q;
    logic                  err_q;
    logic [DW-1:0]         shadow_q [N_TAPS];
    logic [DW-1:0]         shadow_d [N_TAPS];
    logic [N_TAPS*DW-1:0]  active_q;
    logic [DW-1:0]         sample_q;
    logic [DW-1:0]         fifo_mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [15:0]           sample_cnt_q;

    logic addr_ok, accept, push, pop, timeout_hit, recover_done, gap_done;

    // ---------------------------------------------------------------------
    // Handshake and event decode
    // ---------------------------------------------------------------------
    assign addr_ok = (int'(cfg_addr) < N_TAPS);

    // rst_hold_q keeps s_ready low through reset and the first cycle after it.
    assign s_ready = ~rst_hold_q & (state_q == S_IDLE) & ~pending_q &
                     (fifo_cnt_q != 2'd2);
    assign accept  = s_valid & s_ready;

    // fir_valid_out is only meaningful while a sample is in flight.
    assign push         = (state_q == S_WAIT) & fir_valid_out;
    assign pop          = m_valid & m_ready;
    assign timeout_hit  = (state_q == S_WAIT) & ~fir_valid_out &
                          (cnt_q == CW'(TIMEOUT - 1));
    assign gap_done     = (state_q == S_GAP) & (cnt_q == CW'(GAP - 1));
    assign recover_done = (state_q == S_RECOVER) & (cnt_q == CW'(1));

    // ---------------------------------------------------------------------
    // Shadow bank with this cycle's write applied. LOAD_COPY copies this
    // view, so a write in the copy cycle reaches the active bank.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        shadow_d = shadow_q;
        if (cfg_we && addr_ok) begin
            shadow_d[cfg_addr] = cfg_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q)   state_d = S_LOAD_COPY;
                else if (accept) state_d = S_ISSUE;
            end
            S_LOAD_COPY:  state_d = S_LOAD_PULSE;
            S_LOAD_PULSE: state_d = S_IDLE;
            S_ISSUE:      state_d = S_WAIT;
            S_WAIT: begin
                if (fir_valid_out)    state_d = S_GAP;
                else if (timeout_hit) state_d = S_RECOVER;
            end
            S_GAP:        if (gap_done)     state_d = S_IDLE;
            S_RECOVER:    if (recover_done) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State register, counter and control flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rst_hold_q <= 1'b1;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
            rst_hold_q <= 1'b0;
            // A commit arriving while one is already pending (including the
            // copy cycle itself) is merged into that one.
            if (state_q == S_LOAD_COPY)
                pending_q <= 1'b0;
            else if (cfg_commit || recover_done)
                pending_q <= 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Coefficient banks and sample register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) shadow_q[i] <= '0;
            active_q <= '0;
            sample_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (state_q == S_LOAD_COPY) begin
                for (int i = 0; i < N_TAPS; i++) active_q[DW*i +: DW] <= shadow_d[i];
            end
            if (accept)
                sample_q <= s_data;
        end
    end

    // ---------------------------------------------------------------------
    // 2-entry output FIFO and result counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: storage arrays normally skip reset; this one is cleared
        // because its head drives m_data, which must read zero after reset.
        if (!rst) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            sample_cnt_q  <= 16'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= fir_signal_out;
                wr_ptr_q             <= ~wr_ptr_q;
                sample_cnt_q         <= sample_cnt_q + 16'd1;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ---------------------------------------------------------------------
    assign busy          = (state_q != S_IDLE) | pending_q;
    assign m_valid       = (fifo_cnt_q != 2'd0);
    assign m_data        = fifo_mem_q[rd_ptr_q];
    assign fir_rst       = rst_hold_q | (state_q == S_RECOVER);
    assign fir_load      = (state_q == S_LOAD_PULSE);
    assign fir_coeff     = active_q;
    assign fir_valid_in  = (state_q == S_ISSUE);
    assign fir_signal_in = sample_q;
    assign err_timeout   = err_q;
    assign sample_cnt    = sample_cnt_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_ctrl
//
// Directed bench for fir_ctrl. A small fir model (3-cycle latency, result =
// sample + loaded tap0, cleared by fir_rst) answers the DUT. Expected results
// are queued when a sample is accepted and compared when the DUT presents
// them on the output port.
// ---------------------------------------------------------------------------
module tb_fir_ctrl;

    localparam int N_TAPS  = 6;
    localparam int DW      = 16;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 32;

    logic                 clk;
    logic                 rst;
    logic                 cfg_we;
    logic [2:0]           cfg_addr;
    logic [DW-1:0]        cfg_wdata;
    logic                 cfg_commit;
    logic                 busy;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_data;
    logic                 fir_rst;
    logic                 fir_load;
    logic [N_TAPS*DW-1:0] fir_coeff;
    logic                 fir_valid_in;
    logic [DW-1:0]        fir_signal_in;
    logic                 fir_valid_out;
    logic [DW-1:0]        fir_signal_out;
    logic                 err_timeout;
    logic [15:0]          sample_cnt;

    fir_ctrl #(.N_TAPS(N_TAPS), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_commit     (cfg_commit),
        .busy           (busy),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .fir_rst        (fir_rst),
        .fir_load       (fir_load),
        .fir_coeff      (fir_coeff),
        .fir_valid_in   (fir_valid_in),
        .fir_signal_in  (fir_signal_in),
        .fir_valid_out  (fir_valid_out),
        .fir_signal_out (fir_signal_out),
        .err_timeout    (err_timeout),
        .sample_cnt     (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                last_vi = -1;
    int                load_cnt = 0;
    int                exp_cnt = 0;
    logic [DW-1:0]     exp_tap0 = '0;
    logic [DW-1:0]     exp_q[$];
    logic [N_TAPS*DW-1:0] coeff_exp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- fir model ----------------
    logic [2:0]    vpipe;
    logic [DW-1:0] dpipe [3];
    logic [DW-1:0] model_tap0;
    logic          withhold;

    always @(posedge clk) begin
        if (fir_rst) begin
            vpipe      <= '0;
            model_tap0 <= '0;
        end else begin
            vpipe    <= {vpipe[1:0], fir_valid_in};
            dpipe[0] <= fir_signal_in + model_tap0;
            dpipe[1] <= dpipe[0];
            dpipe[2] <= dpipe[1];
            if (fir_load) model_tap0 <= fir_coeff[DW-1:0];
        end
    end
    assign fir_valid_out  = vpipe[2] & ~withhold;
    assign fir_signal_out = dpipe[2];

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        #1;
        if (rst && m_valid && m_ready) begin
            check("out_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("out_data", m_data, exp_q.pop_front());
        end
        if (fir_load) load_cnt++;
        if (fir_valid_in) begin
            if (last_vi >= 0) check("vi_spacing", ((cyc - last_vi) >= GAP + 2), 1);
            last_vi = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [DW-1:0] d, input bit expect_out, input bit commit_too);
        bit ok;
        s_data  = d;
        s_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (s_ready) break;
            @(negedge clk);
        end
        ok = s_ready;
        check("send_accept", s_ready, 1);
        if (ok) begin
            cfg_commit = commit_too;
            if (expect_out) begin
                exp_q.push_back(d + exp_tap0);
                exp_cnt++;
            end
        end
        @(negedge clk);
        s_valid    = 1'b0;
        cfg_commit = 1'b0;
        if (ok) begin
            check("vi_latency", fir_valid_in, 1);
            check("vi_data", fir_signal_in, d);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !busy && !m_valid) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_load(output bit found);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (fir_load) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit            found;
        int            k;
        logic [DW-1:0] d, hold;

        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; withhold = 1'b0;
        coeff_exp = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_fir_rst", fir_rst, 1);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_fir_load", fir_load, 0);
        check("rst_fir_coeff", fir_coeff, 0);
        check("rst_err", err_timeout, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check("fir_rst_drop", fir_rst, 0);
        check("ready_after_rst", s_ready, 1);

        // 1. Coefficients 1..6, out-of-range writes ignored, commit
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wdata = (i < N_TAPS) ? 16'(i + 1) : 16'hDEAD;
            if (i < N_TAPS) coeff_exp[DW*i +: DW] = 16'(i + 1);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        check("shadow_only", fir_coeff, 0);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("busy_pending", busy, 1);
        wait_load(found);
        check("load1_seen", found, 1);
        check("coeff_loaded", fir_coeff, coeff_exp);
        exp_tap0 = 16'd1;
        @(negedge clk);
        check("load1_one_cycle", fir_load, 0);
        check("load_cnt1", load_cnt, 1);

        // 2. 128 samples streaming with m_ready high
        for (int i = 0; i < 128; i++) begin
            d = 16'($urandom);
            send(d, 1'b1, 1'b0);
        end
        wait_drain();
        check("sample_cnt_128", sample_cnt, 128);

        // 3. Output back-pressure: two accepted, third blocked until release
        m_ready = 1'b0;
        send(16'h1111, 1'b1, 1'b0);
        send(16'h2222, 1'b1, 1'b0);
        s_data = 16'h3333; s_valid = 1'b1;
        repeat (30) @(negedge clk);
        check("full_s_ready", s_ready, 0);
        check("full_m_valid", m_valid, 1);
        check("full_head", m_data, exp_q[0]);
        hold = m_data;
        repeat (3) @(negedge clk);
        check("head_stable", m_data, hold);
        m_ready = 1'b1;
        send(16'h3333, 1'b1, 1'b0);
        wait_drain();
        check("sample_cnt_131", sample_cnt, 16'(exp_cnt));

        // 4. Shadow write mid-run, then commit together with a handshake
        send(16'h0400, 1'b1, 1'b0);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'd100;
        @(negedge clk);
        cfg_we = 1'b0;
        check("coeff_hold", fir_coeff, coeff_exp);
        wait_drain();
        check("coeff_hold_idle", fir_coeff, coeff_exp);
        send(16'h0500, 1'b1, 1'b1);
        wait_load(found);
        check("load2_seen", found, 1);
        check("result_before_load", exp_q.size(), 0);
        coeff_exp[DW-1:0] = 16'd100;
        check("coeff_tap0_new", fir_coeff, coeff_exp);
        exp_tap0 = 16'd100;
        @(negedge clk);
        check("load_cnt2", load_cnt, 2);
        send(16'h0600, 1'b1, 1'b0);
        wait_drain();
        check("sample_cnt_t4", sample_cnt, 16'(exp_cnt));

        // 5. fir never answers: timeout, two-cycle fir_rst, forced reload
        withhold = 1'b1;
        send(16'h0700, 1'b0, 1'b0);
        k = 0;
        while (k < 60 && !err_timeout) begin
            @(negedge clk);
            k++;
        end
        check("timeout_delay", (k >= TIMEOUT && k <= TIMEOUT + 2), 1);
        check("recover_rst0", fir_rst, 1);
        @(negedge clk);
        check("recover_rst1", fir_rst, 1);
        @(negedge clk);
        check("recover_rst_drop", fir_rst, 0);
        withhold = 1'b0;
        wait_load(found);
        check("reload_seen", found, 1);
        @(negedge clk);
        check("load_cnt3", load_cnt, 3);
        check("dropped_not_counted", sample_cnt, 16'(exp_cnt));
        send(16'h0800, 1'b1, 1'b0);
        wait_drain();
        check("err_sticky", err_timeout, 1);
        check("sample_cnt_t5", sample_cnt, 16'(exp_cnt));

        // 6. Asynchronous reset in the middle of WAIT
        send(16'h0900, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_fir_rst", fir_rst, 1);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vi", fir_valid_in, 0);
        check("mid_rst_coeff", fir_coeff, 0);
        check("mid_rst_cnt", sample_cnt, 0);
        check("mid_rst_err", err_timeout, 0);
        exp_q.delete();
        exp_cnt  = 0;
        exp_tap0 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_fir_rst", fir_rst, 0);
        send(16'h0A0A, 1'b1, 1'b0);
        wait_drain();
        check("post_rst_cnt", sample_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
